// File: rtl/output_module.sv
// -----------------------------------------------------------------------------
// output_module
//
// Per-direction output stage of the router. Round-robin arbitrates among the
// five input modules that hold a flit for this direction, buffers the winners
// in a small register FIFO, and drains the FIFO into the downstream input FIFO
// using its full / write handshake.
//
// Parameters
//   MSB_SLOT : log2 of flit width
//   DSIZE    : flit width in bits (1 << MSB_SLOT)
//   PORT     : direction driven by this instance (N=0, S=1, E=2, W=3, L=4)
//   DEPTH    : FIFO entries (power of two, >= 2)
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   reset        : synchronous, active-high
//   req          : per-input-port request for this direction (N,S,E,W,L order)
//   data_in      : packed flits, port i at [i*DSIZE +: DSIZE]
//   grant        : one-hot (or zero) acceptance of a requester's flit
//   output_full  : downstream FIFO cannot take a flit this cycle
//   output_write : data_out is written downstream at this edge
//   data_out     : FIFO head flit
//   count        : current FIFO occupancy
// -----------------------------------------------------------------------------
module output_module #(
  parameter int          MSB_SLOT = 5,
  parameter int          DSIZE    = 1 << MSB_SLOT,
  parameter logic [2:0]  PORT     = 3'b000,
  parameter int          DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [4:0]               req,
  input  logic [5*DSIZE-1:0]       data_in,
  output logic [4:0]               grant,
  input  logic                     output_full,
  output logic                     output_write,
  output logic [DSIZE-1:0]         data_out,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [2:0] PORT_L = 3'd4;

  // Unpacked view of the five incoming flits.
  logic [DSIZE-1:0] flit [5];

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_unpack
      assign flit[gi] = data_in[gi*DSIZE +: DSIZE];
    end
  endgenerate

  // State
  logic [DSIZE-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [2:0]       rr_ptr_reg;

  // Next-state / combinational signals
  logic [4:0]       eligible;
  logic             win_valid;
  logic [2:0]       win_idx;
  logic             fifo_full;
  logic             push;
  logic             pop;
  logic [CW-1:0]    count_next;
  logic [2:0]       rr_ptr_next;

  // No U-turn: a router never sends a flit back the way it came, except the
  // local port which may loop back to its own core.
  assign eligible = (PORT == PORT_L) ? req : (req & ~(5'b00001 << PORT));

  // Round-robin search starting at rr_ptr, wrapping 4 -> 0.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = 3'd0;
    for (int k = 0; k < 5; k++) begin
      int c;
      c = int'(rr_ptr_reg) + k;
      if (c >= 5) c = c - 5;
      if (!win_valid && eligible[c]) begin
        win_valid = 1'b1;
        win_idx   = 3'(c);
      end
    end
  end

  // count is the only source of full/empty. Grant deliberately ignores
  // output_full so there is no combinational path from downstream to inputs.
  assign fifo_full    = (count_reg == CW'(DEPTH));
  assign push         = win_valid && !fifo_full && !reset;
  assign pop          = (count_reg != '0) && !output_full && !reset;

  assign grant        = push ? (5'b00001 << win_idx) : 5'b00000;
  assign output_write = pop;
  assign data_out     = mem_reg[rd_ptr_reg];
  assign count        = count_reg;

  always_comb begin
    count_next = count_reg;
    unique case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  assign rr_ptr_next = (win_idx == 3'd4) ? 3'd0 : (win_idx + 3'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      rr_ptr_reg <= 3'd0;
      // Clearing storage makes data_out read 0 after reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_reg[wr_ptr_reg] <= flit[win_idx];
        wr_ptr_reg          <= wr_ptr_reg + AW'(1);
        rr_ptr_reg          <= rr_ptr_next;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_next;
    end
  end

endmodule

// File: tb/tb_output_module.sv
// -----------------------------------------------------------------------------
// tb_output_module
//
// One output_module instance per direction (N,S,E,W,L), all sharing the same
// stimulus. A queue-based reference model per instance predicts grant,
// output_write, count and data_out every cycle.
// -----------------------------------------------------------------------------
module tb_output_module;

  localparam int DSIZE = 32;
  localparam int DEPTH = 4;

  logic               clk;
  logic               reset;
  logic [4:0]         req;
  logic [5*DSIZE-1:0] data_in;
  logic               output_full;

  logic [4:0]         grant_w [5];
  logic               write_w [5];
  logic [DSIZE-1:0]   dout_w  [5];
  logic [2:0]         count_w [5];

  int tests_run;
  int tests_failed;

  // Reference model state
  logic [DSIZE-1:0] q [5][$];
  int               rr [5];
  bit               fresh [5];

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_dut
      output_module #(
        .MSB_SLOT(5),
        .DSIZE(DSIZE),
        .PORT(3'(gi)),
        .DEPTH(DEPTH)
      ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .data_in(data_in),
        .grant(grant_w[gi]),
        .output_full(output_full),
        .output_write(write_w[gi]),
        .data_out(dout_w[gi]),
        .count(count_w[gi])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Which port the rules say should win for direction p, or -1.
  function automatic int model_winner(int p);
    for (int k = 0; k < 5; k++) begin
      int c;
      c = (rr[p] + k) % 5;
      if (req[c] && (p == 4 || c != p)) return c;
    end
    return -1;
  endfunction

  task automatic step();
    int  win [5];
    bit  ew  [5];
    logic [4:0] eg;
    @(negedge clk);
    for (int p = 0; p < 5; p++) begin
      win[p] = -1;
      if (!reset && q[p].size() < DEPTH) win[p] = model_winner(p);
      ew[p]  = !reset && (q[p].size() > 0) && !output_full;
      eg     = (win[p] >= 0) ? (5'b00001 << win[p]) : 5'b00000;
      check($sformatf("grant[%0d]", p), 32'(grant_w[p]), 32'(eg));
      check($sformatf("write[%0d]", p), 32'(write_w[p]), 32'(ew[p]));
      check($sformatf("count[%0d]", p), 32'(count_w[p]), 32'(q[p].size()));
      if (q[p].size() > 0)
        check($sformatf("data_out[%0d]", p), dout_w[p], q[p][0]);
      else if (fresh[p])
        check($sformatf("data_out0[%0d]", p), dout_w[p], 32'h0);
    end
    @(posedge clk);
    for (int p = 0; p < 5; p++) begin
      if (reset) begin
        q[p].delete();
        rr[p]    = 0;
        fresh[p] = 1'b1;
      end else begin
        if (ew[p]) void'(q[p].pop_front());
        if (win[p] >= 0) begin
          q[p].push_back(data_in[win[p]*DSIZE +: DSIZE]);
          rr[p]    = (win[p] + 1) % 5;
          fresh[p] = 1'b0;
        end
      end
    end
    $display("[TB] t=%0t reset=%b req=%b full=%b grants=%b/%b/%b/%b/%b counts=%0d/%0d/%0d/%0d/%0d",
             $time, reset, req, output_full, grant_w[0], grant_w[1], grant_w[2],
             grant_w[3], grant_w[4], count_w[0], count_w[1], count_w[2], count_w[3], count_w[4]);
    #1;
  endtask

  task automatic tag_flits();
    for (int i = 0; i < 5; i++) data_in[i*DSIZE +: DSIZE] = 32'(i << 4);
  endtask

  task automatic rand_flits();
    for (int i = 0; i < 5; i++) data_in[i*DSIZE +: DSIZE] = $urandom;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    for (int p = 0; p < 5; p++) begin
      rr[p]    = 0;
      fresh[p] = 1'b1;
    end
    reset       = 1'b1;
    req         = 5'b11111;
    output_full = 1'b0;
    tag_flits();
    @(posedge clk);
    #1;

    // Reset held with all requests active.
    step();
    step();

    // Round-robin with every port requesting, tagged flits.
    reset = 1'b0;
    for (int i = 0; i < 10; i++) step();

    // Backpressure until full, then release.
    reset = 1'b1; step();
    reset = 1'b0;
    req = 5'b00011;
    output_full = 1'b1;
    for (int i = 0; i < 7; i++) step();
    output_full = 1'b0;
    for (int i = 0; i < 4; i++) step();
    req = 5'b00000;
    for (int i = 0; i < 5; i++) step();

    // Single flit from port 0.
    reset = 1'b1; step();
    reset = 1'b0;
    data_in[0 +: DSIZE] = 32'h01020001;
    req = 5'b00001;
    step();
    req = 5'b00000;
    for (int i = 0; i < 3; i++) step();

    // U-turn mask: port 0 requesting for 5 cycles while N stays empty.
    req = 5'b00001;
    output_full = 1'b1;
    for (int i = 0; i < 5; i++) step();
    output_full = 1'b0;
    req = 5'b00000;
    for (int i = 0; i < 5; i++) step();

    // Steady push/pop, then build occupancy and reset mid-run.
    req = 5'b00001;
    for (int i = 0; i < 6; i++) begin
      data_in[0 +: DSIZE] = 32'hA000_0000 | 32'(i);
      step();
    end
    req = 5'b00000; step();
    output_full = 1'b1;
    req = 5'b00011;
    for (int i = 0; i < 3; i++) step();
    reset = 1'b1; req = 5'b00000; step();
    reset = 1'b0; output_full = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      req         = 5'($urandom);
      rand_flits();
      output_full = ($urandom_range(0, 2) == 0);
      reset       = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/output_module.md
# output_module

Per-port output stage of the router; the write-side counterpart of `input_module`. It arbitrates round-robin among the five input modules requesting this output direction and buffers the winning flits in a small FIFO. It then writes them into the downstream (neighbour router or local core) input FIFO using the same empty/full, read/write handshake that `input_module` consumes on its side. One instance sits on each of the N, S, E, W and L outputs of the crossbar.

## Interface
- `MSB_SLOT`, 5, log2 of flit width.
- `DSIZE`, `1<<MSB_SLOT` (32), flit width in bits.
- `PORT`, `3'b000`, direction this instance drives: N=000, S=001, E=010, W=011, L=100.
- `DEPTH`, 4, output FIFO entries; power of two, ≥2.
- `clk`  input  1  single clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-high.
- `req`  input  5  request vector; bit i = input port i (N,S,E,W,L order) holds a flit routed to `PORT`.
- `data_in`  input  5*DSIZE  packed flits; port i at `[i*DSIZE +: DSIZE]`.
- `grant`  output  5  one-hot or zero; bit i = flit from port i is accepted at this edge.
- `output_full`  input  1  downstream FIFO cannot accept a flit this cycle.
- `output_write`  output  1  `data_out` is written downstream at this edge.
- `data_out`  output  DSIZE  FIFO head flit.
- `count`  output  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Eligible requests: `req` with bit `PORT` masked to 0 when `PORT != L` (no U-turn). When `PORT == L`, all five bits are eligible (local loopback).
- Arbiter: round-robin pointer `rr_ptr` (3 bits, values 0..4). The search starts at `rr_ptr` and wraps 4→0. The first eligible requester wins.
- `grant` is combinational: the winner's bit is asserted only if `count < DEPTH`, otherwise `grant` = 0.
- On an edge with nonzero `grant`:
  - the winner's flit is pushed to the FIFO tail, unmodified (header bits [31:24] X and [23:16] Y are passed through);
  - `rr_ptr` ← winner+1, wrapping 4→0.
- `rr_ptr` holds when there is no grant.
- Drain: `output_write = (count != 0) && !output_full`, combinational. The head is popped on each edge where `output_write` = 1.
- Simultaneous push and pop: occupancy is unchanged and both pointers advance.
- Full FIFO: no grant, even if a pop occurs in the same cycle. `grant` never depends on `output_full`, so there is no combinational path from the downstream side back to the inputs.
- Empty FIFO:
  - `output_write` = 0;
  - `data_out` is the stale last-popped value, or 0 after reset;
  - there is no bypass, so a flit never passes from `data_in` to `data_out` in the same cycle.
- Read/write pointers are $clog2(DEPTH) bits and wrap naturally. `count` is the single source of full/empty.
- FIFO storage is registers. `data_out` = `mem[rd_ptr]`.

## Timing
- Reset (`reset` high at an edge):
  - `count`, `rr_ptr`, `rd_ptr` and `wr_ptr` ← 0;
  - `data_out` reads 0 (memory cleared);
  - `grant` = 0 and `output_write` = 0 for the whole cycle in which `reset` is high.
- Reset mid-operation discards all buffered flits. There is no partial drain.
- Latency: a flit granted at edge n is on `data_out` with `output_write` high in cycle n+1 at the earliest, if it reaches the head and `output_full` = 0.
- Throughput: one flit per cycle in and one flit per cycle out when not full and downstream not full.
- Backpressure: `output_full` high holds the head and `data_out` stable. Arbitration continues until `count == DEPTH`.
- Fairness: with all eligible ports continuously requesting, each port is granted once every (number of eligible ports) grants.

## Test plan
- Reset: hold `reset` 2 cycles with `req`=5'b11111 and `output_full`=0.
  - Required: `grant`=0, `output_write`=0, `count`=0, `data_out`=0 throughout.
  - After release, the first grant goes to the lowest eligible index.
- Single flit, `PORT`=S: `req`=5'b00001 with port 0 flit 32'h01020001.
  - Cycle n: `grant`=5'b00001.
  - Cycle n+1: `output_write`=1 and `data_out`=32'h01020001.
  - Cycle n+2: `count`=0 and `output_write`=0.
- U-turn mask, `PORT`=N: `req`=5'b00001 held 5 cycles.
  - Required: `grant` stays 0 and `count` stays 0.
  - Same stimulus with `PORT`=L: granted.
- Round-robin, `PORT`=L: `req`=5'b11111 for 10 cycles, `output_full`=0.
  - Required grant sequence: ports 0,1,2,3,4,0,1,2,3,4.
  - `data_out` sequence matches the tagged flits 32'h000000i0.
- Backpressure/full, `PORT`=E: `output_full`=1 with `req`=5'b00011.
  - Required: 4 grants (0,1,0,1), then `grant`=0 and `count`=4.
  - `output_write` stays 0 and `data_out` is held.
  - Release `output_full`: 4 consecutive writes in order, and new grants resume in the same cycle `count` drops below 4.
- Simultaneous push/pop plus mid-run reset: steady-state in/out at 1 flit/cycle.
  - Required: `count` constant at 1.
  - Assert `reset` with `count`=3: `count` is 0 next cycle and no buffered flit is ever written.
